// File: rtl/ifft_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// ifft_butterfly_pipe
//   Three-stage radix-2 DIF inverse butterfly:
//     o_A = A + B
//     o_B = (A - B) * conj(W)
//   Each output component is rounded half-up, optionally divided by 2, and
//   saturated to 16 bits. Stages advance together under a single enable, so
//   the whole pipe stalls when the output holds a beat that is not accepted.
//
// Ports
//   i_CLK      clock, rising edge
//   i_RST      asynchronous active-low reset
//   i_VALID    input beat valid
//   o_READY    block accepts an input beat this cycle
//   i_SCALE    1 = divide both outputs by 2 (travels with the beat)
//   i_A, i_B   complex operands {real[31:16], imag[15:0]}, Q9.6
//   i_TWIDDLE  twiddle W, conjugated internally
//   o_VALID    output beat valid
//   i_READY    downstream accepts the output beat
//   o_A        {Sr, Si} sum result
//   o_B        {Pr, Pi} product result
//   o_SAT      any of the four output components saturated on this beat
// ---------------------------------------------------------------------------
module ifft_butterfly_pipe #(
  parameter int WORD_SZ  = 32,
  parameter int WORD_MID = 16,
  parameter int FRAC     = 6
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_VALID,
  output logic               o_READY,
  input  logic               i_SCALE,
  input  logic [WORD_SZ-1:0] i_A,
  input  logic [WORD_SZ-1:0] i_B,
  input  logic [WORD_SZ-1:0] i_TWIDDLE,
  output logic               o_VALID,
  input  logic               i_READY,
  output logic [WORD_SZ-1:0] o_A,
  output logic [WORD_SZ-1:0] o_B,
  output logic               o_SAT
);

  localparam int CW = WORD_MID;      // component width
  localparam int DW = CW + 1;        // sum/difference width, never wraps
  localparam int PW = 2 * CW + 2;    // partial product width
  localparam int AW = PW + 2;        // accumulate/round width, headroom for +/- and rounding

  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (CW - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  // Round half-up then arithmetic shift right by k; k = 0 passes through.
  function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] x,
                                                       input int k);
    logic signed [AW-1:0] half;
    half = '0;
    if (k > 0) begin
      half        = {{(AW-1){1'b0}}, 1'b1} << (k - 1);
      round_shift = (x + half) >>> k;
    end else begin
      round_shift = x;
    end
  endfunction

  // Returns {saturated, clamped component}.
  function automatic logic [CW:0] saturate(input logic signed [AW-1:0] x);
    if (x > SAT_MAX)      saturate = {1'b1, SAT_MAX[CW-1:0]};
    else if (x < SAT_MIN) saturate = {1'b1, SAT_MIN[CW-1:0]};
    else                  saturate = {1'b0, x[CW-1:0]};
  endfunction

  // Operand unpacking, sign-extended so the stage-1 add/sub cannot wrap.
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  assign a_re = DW'($signed(i_A[WORD_SZ-1:WORD_MID]));
  assign a_im = DW'($signed(i_A[WORD_MID-1:0]));
  assign b_re = DW'($signed(i_B[WORD_SZ-1:WORD_MID]));
  assign b_im = DW'($signed(i_B[WORD_MID-1:0]));

  // One enable for every stage: bubbles are kept, nothing is collapsed.
  logic en;
  assign en      = !o_VALID || i_READY;
  assign o_READY = en;

  // Stage 1: sum, difference, twiddle, scale.
  logic                 s1_valid, s1_scale;
  logic signed [DW-1:0] s1_sr, s1_si, s1_dr, s1_di;
  logic signed [CW-1:0] s1_wr, s1_wi;

  // Stage 2: four partial products, sum carried along.
  logic                 s2_valid, s2_scale;
  logic signed [DW-1:0] s2_sr, s2_si;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ir, s2_ri;

  // Stage 3: rounded, saturated outputs.
  logic                 s3_valid, s3_sat;
  logic [WORD_SZ-1:0]   s3_a, s3_b;

  // Stage-3 combinational datapath.
  logic [CW:0] sr_q, si_q, pr_q, pi_q;
  int          k_s, k_p;

  // NOTE: every variable written here gets a value on every path before use,
  // otherwise the block would infer a latch.
  always_comb begin
    k_s  = s2_scale ? 1 : 0;
    k_p  = s2_scale ? FRAC + 1 : FRAC;
    sr_q = saturate(round_shift(AW'(s2_sr), k_s));
    si_q = saturate(round_shift(AW'(s2_si), k_s));
    // conj(W) flips the sign of Wi: (Dr + jDi)(Wr - jWi).
    pr_q = saturate(round_shift(AW'(s2_rr) + AW'(s2_ii), k_p));
    pi_q = saturate(round_shift(AW'(s2_ir) - AW'(s2_ri), k_p));
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_sr    <= '0;
      s1_si    <= '0;
      s1_dr    <= '0;
      s1_di    <= '0;
      s1_wr    <= '0;
      s1_wi    <= '0;
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_sr    <= '0;
      s2_si    <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ir    <= '0;
      s2_ri    <= '0;
      s3_valid <= 1'b0;
      s3_sat   <= 1'b0;
      s3_a     <= '0;
      s3_b     <= '0;
    end else if (en) begin
      s1_valid <= i_VALID;
      s1_scale <= i_SCALE;
      s1_sr    <= a_re + b_re;
      s1_si    <= a_im + b_im;
      s1_dr    <= a_re - b_re;
      s1_di    <= a_im - b_im;
      s1_wr    <= $signed(i_TWIDDLE[WORD_SZ-1:WORD_MID]);
      s1_wi    <= $signed(i_TWIDDLE[WORD_MID-1:0]);

      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_sr    <= s1_sr;
      s2_si    <= s1_si;
      s2_rr    <= PW'(s1_dr) * PW'(s1_wr);
      s2_ii    <= PW'(s1_di) * PW'(s1_wi);
      s2_ir    <= PW'(s1_di) * PW'(s1_wr);
      s2_ri    <= PW'(s1_dr) * PW'(s1_wi);

      s3_valid <= s2_valid;
      s3_sat   <= sr_q[CW] | si_q[CW] | pr_q[CW] | pi_q[CW];
      s3_a     <= {sr_q[CW-1:0], si_q[CW-1:0]};
      s3_b     <= {pr_q[CW-1:0], pi_q[CW-1:0]};
    end
  end

  assign o_VALID = s3_valid;
  assign o_A     = s3_a;
  assign o_B     = s3_b;
  assign o_SAT   = s3_sat;

endmodule
